gate_check_sequencer: RTL

//  Self-test controller for the five-output basic-gate unit (inputs a,b; outputs g1..g5).
//  On a start pulse it drives the 4 input vectors {a,b}=00,01,10,11 in that order.
//  It holds each vector HOLD_CYCLES clocks, samples g[5:1] and compares it with the truth table.
//  It reports per-vector mismatches and an overall pass flag.

---
 rtl/gate_check_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gate_check_sequencer.sv
// gate_check_sequencer: self-test sequencer for the five-output basic-gate unit.
// Latency: done pulses 4*HOLD_CYCLES+1 edges after the edge that accepts start.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) otherwise.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-high reset
//   i_start     run request, honoured only while idle
//   i_g[4:0]    gate unit outputs {g5,g4,g3,g2,g1}
//   o_a, o_b    registered drive to gate unit inputs a, b
//   o_busy      high while vectors are being applied
//   o_done      one-cycle end-of-run pulse
//   o_pass      last run had no mismatches (valid from done until next accepted start)
//   o_err_mask  bit i set when vector {a,b}=i mismatched
//
// Parameters: HOLD_CYCLES (1..255) clocks each vector is held; CNT_W hold counter width,
// 2**CNT_W must exceed HOLD_CYCLES.
// Optional build macro: GATE_CHECK_ABORT_ON_FAIL_EN -- when defined the first mismatching
// sample ends the run immediately; otherwise all four vectors are always applied.

module gate_check_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [4:0] i_g,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_mask
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter value on which the current vector is sampled.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_err_mask;

    logic [4:0]       w_exp;
    logic             w_miss;

    // Truth table of the gate unit for vector {a,b}=v, packed {g5,g4,g3,g2,g1}.
    function automatic logic [4:0] f_expected(input logic [1:0] v);
        logic va;
        logic vb;
        va = v[1];
        vb = v[0];
        return {~(va | vb), ~(va & vb), ~va, va | vb, va & vb};
    endfunction

    assign w_exp  = f_expected(r_idx);
    // Only consumed on the sample edge, so X on i_g elsewhere never reaches state.
    assign w_miss = (i_g != w_exp);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_mask <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= ST_APPLY;
                        r_idx      <= 2'd0;
                        r_cnt      <= '0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_err_mask <= 4'd0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_APPLY: begin
                    if (r_cnt < LP_CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Sample edge for vector r_idx.
                        if (w_miss) begin
                            r_err_mask[r_idx] <= 1'b1;
                        end
`ifdef GATE_CHECK_ABORT_ON_FAIL_EN
                        if (w_miss || (r_idx == 2'd3)) begin
`else
                        if (r_idx == 2'd3) begin
`endif
                            // a,b stay on the last applied vector until the next start.
                            r_state <= ST_DONE;
                        end else begin
                            r_idx        <= r_idx + 2'd1;
                            r_cnt        <= '0;
                            {r_a, r_b}   <= r_idx + 2'd1;
                        end
                    end
                end

                ST_DONE: begin
                    // err_mask already includes the final sample, so pass is exact here.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_pass  <= (r_err_mask == 4'd0);
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_err_mask = r_err_mask;

endmodule
